// File: rtl/pipe_pkg.sv
// Shared definitions for the core pipeline stage registers: ID/EX payload
// layout, its NOP bubble, and the skid-buffer state encoding.
package pipe_pkg;

    localparam int PC_W      = 32;
    localparam int OPCODE_W  = 7;
    localparam int REG_W     = 32;
    localparam int REGADDR_W = 5;

    localparam logic [REGADDR_W-1:0] NOP_REG_ADDR = 5'b00000;
    localparam logic                 WREG_DISABLE = 1'b0;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [OPCODE_W-1:0]  opcode;
        logic [REG_W-1:0]     reg1;
        logic [REG_W-1:0]     reg2;
        logic [REGADDR_W-1:0] wd;
        logic                 wreg;
        logic [REG_W-1:0]     imm;
    } id_ex_t;

    localparam int ID_EX_W = $bits(id_ex_t);

    localparam id_ex_t ID_EX_NOP = '{
        pc:     32'h0000_0000,
        opcode: 7'b000_0000,
        reg1:   32'h0000_0000,
        reg2:   32'h0000_0000,
        wd:     NOP_REG_ADDR,
        wreg:   WREG_DISABLE,
        imm:    32'h0000_0000
    };

    // bit0 = main entry valid, bit1 = skid entry valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// CNT_W-wide event counter that sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_r;

    // Count qualifying cycles, holding once the maximum is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with a 2-entry skid buffer and branch flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/flush counter ports.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = ID_EX_W,
    parameter logic [DATA_W-1:0]  NOP_DATA = {DATA_W{1'b0}},
    parameter int                 CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
`endif
    output logic [DATA_W-1:0] out_data_o
);

    pipe_state_e       state_r;
    pipe_state_e       state_s;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] main_s;
    logic [DATA_W-1:0] skid_r;
    logic [DATA_W-1:0] skid_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              skid_valid_s;

    assign in_fire_s    = in_valid_i & in_ready_r;
    assign out_fire_s   = out_valid_r & out_ready_i;
    assign skid_valid_s = (state_r == ST_TWO);

    // Next-state and entry update; flush wins over every handshake.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush_i) begin
            state_s = ST_EMPTY;
            main_s  = NOP_DATA;
            skid_s  = NOP_DATA;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_s = ST_ONE;
                        main_s  = in_data_i;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_s = in_data_i;
                    end else if (in_fire_s) begin
                        state_s = ST_TWO;
                        skid_s  = in_data_i;
                    end else if (out_fire_s) begin
                        state_s = ST_EMPTY;
                        main_s  = NOP_DATA;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_fire_s) begin
                        state_s = ST_ONE;
                        main_s  = skid_r;
                        skid_s  = NOP_DATA;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                    main_s  = NOP_DATA;
                    skid_s  = NOP_DATA;
                end
            endcase
        end
    end

    // Handshake flags are registered from the next state so neither ready
    // nor valid has a combinational path from the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            main_r      <= NOP_DATA;
            skid_r      <= NOP_DATA;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            main_r      <= main_s;
            skid_r      <= skid_s;
            in_ready_r  <= (state_s != ST_TWO);
            out_valid_r <= (state_s != ST_EMPTY);
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = main_r;

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid_r & ~out_ready_i),
        .cnt (stall_cnt_o)
    );

    // Only a squash of a live beat counts, not a flush of an idle stage.
    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_i & (out_valid_r | skid_valid_s)),
        .cnt (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, back-pressure, flush;
// counter saturation is exercised when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    localparam int DW = 141;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    int n_pass;
    int n_total;
    logic [DW-1:0] delivered[$];

    pipe_stage_reg #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt),
`endif
        .out_data_o  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ext(input logic [7:0] v);
        return {{(DW-8){1'b0}}, v};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Drive one cycle of inputs, log any beat delivered at the edge, end #1 after it.
    task automatic step(input logic f, input logic v, input logic [7:0] d, input logic r);
        flush     = f;
        in_valid  = v;
        in_data   = ext(d);
        out_ready = r;
        #1;
        if (out_valid && out_ready) delivered.push_back(out_data);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       flush;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ready;
    } vec_t;

    vec_t tbl[17];
    logic [7:0] exp_deliv[6];

    initial begin
        n_pass = 0; n_total = 0;
        flush = 1'b0; out_ready = 1'b0;

        // Reset behaviour, including asynchronous assertion mid-transfer
        rst = 1'b1; in_valid = 1'b1; in_data = ext(8'h5A);
        #12;
        check("rst_valid", ext({7'd0, out_valid}), ext(8'h00));
        check("rst_data", out_data, ext(8'h00));
        check("rst_ready", ext({7'd0, in_ready}), ext(8'h01));
        rst = 1'b0;
        #4;
        check("accept_valid", ext({7'd0, out_valid}), ext(8'h01));
        check("accept_data", out_data, ext(8'h5A));
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", ext({7'd0, out_valid}), ext(8'h00));
        check("async_rst_data", out_data, ext(8'h00));
        check("async_rst_ready", ext({7'd0, in_ready}), ext(8'h01));
        #7;
        check("held_rst_valid", ext({7'd0, out_valid}), ext(8'h00));
        #1 rst = 1'b0;
        #9;
        check("post_rst_valid", ext({7'd0, out_valid}), ext(8'h01));
        check("post_rst_data", out_data, ext(8'h5A));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("drain_valid", ext({7'd0, out_valid}), ext(8'h00));
        delivered.delete();

        // Back-to-back streaming with one cycle latency
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, i[7:0], 1'b1);
            check($sformatf("stream_valid_%0d", i), ext({7'd0, out_valid}), ext(8'h01));
            check($sformatf("stream_data_%0d", i), out_data, ext(i[7:0]));
            check($sformatf("stream_ready_%0d", i), ext({7'd0, in_ready}), ext(8'h01));
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("stream_end_valid", ext({7'd0, out_valid}), ext(8'h00));
        check("stream_count", ext(delivered.size()), ext(8'd16));
        delivered.delete();

        // flush, valid, data, ready -> expected valid, data, ready
        tbl[0]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 8'hA2, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 8'hB1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 8'hB1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 8'hB3, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 8'hC1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 8'hD1, 1'b1, 1'b1, 8'hD1, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 8'hD2, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 8'hE1, 1'b0, 1'b1, 8'hE1, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE1, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        exp_deliv = '{8'hA1, 8'hA2, 8'hA3, 8'hC1, 8'hD1, 8'hE1};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].flush, tbl[i].in_valid, tbl[i].in_data, tbl[i].out_ready);
            check($sformatf("vec%0d_valid", i), ext({7'd0, out_valid}), ext({7'd0, tbl[i].exp_valid}));
            check($sformatf("vec%0d_data", i), out_data, ext(tbl[i].exp_data));
            check($sformatf("vec%0d_ready", i), ext({7'd0, in_ready}), ext({7'd0, tbl[i].exp_ready}));
        end

        check("deliv_count", ext(delivered.size()), ext(8'd6));
        for (int i = 0; i < 6; i++) begin
            if (i < delivered.size())
                check($sformatf("deliv_%0d", i), delivered[i], ext(exp_deliv[i]));
        end

`ifdef PIPE_STAGE_PERF_EN
        check("flush_cnt", ext({4'd0, flush_cnt}), ext(8'd3));
        rst = 1'b1; #1;
        check("rst_flush_cnt", ext({4'd0, flush_cnt}), ext(8'd0));
        rst = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        check("stall_sat", ext({4'd0, stall_cnt}), ext(8'd15));
        rst = 1'b1; #1;
        check("rst_stall_cnt", ext({4'd0, stall_cnt}), ext(8'd0));
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
